// File: rtl/repairmb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : repairmb_pkg
// Description : Shared encodings for the REPAIRMB lane-repair step. Holds the
//               session FSM state encoding and the check result encoding, so
//               the module-side checker and the LTSM agree on both.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package repairmb_pkg;

  // Session state: idle, or holding a degraded map while a recheck is awaited.
  typedef enum logic [0:0] {
    S_IDLE         = 1'b0,
    S_WAIT_RECHECK = 1'b1
  } state_e;

  // Classification result. RES_NONE is never produced by the classifier; it
  // stays reserved so an all-zero code never aliases a real outcome.
  typedef enum logic [1:0] {
    RES_NONE        = 2'd0,
    RES_CONTINUE    = 2'd1,
    RES_REPEAT      = 2'd2,
    RES_TRAIN_ERROR = 2'd3
  } result_e;

endpackage : repairmb_pkg
`default_nettype wire

// File: rtl/repairmb_map_classify.sv
`default_nettype none
// ============================================================================
// Module      : repairmb_map_classify
// Description : Combinational classifier for a reported functional-lane map.
//               Decides continue / repeat / train-error for either the first
//               check of a session or a recheck against the stored map.
// Ports       : i_map           - reported functional map (bit=1 lane group ok)
//               i_stored_map    - map stored by the previous repeat
//               i_first_check   - 1 when no session is in progress
//               i_attempts_left - 1 while another repeat is still allowed
//               o_result        - result code (RES_CONTINUE/REPEAT/TRAIN_ERROR)
// Revision    : 1.0 - initial release
// ============================================================================
module repairmb_map_classify
  import repairmb_pkg::*;
#(
  parameter int NUM_GROUPS = 2
) (
  input  logic [NUM_GROUPS-1:0] i_map,
  input  logic [NUM_GROUPS-1:0] i_stored_map,
  input  logic                  i_first_check,
  input  logic                  i_attempts_left,
  output result_e               o_result
);

  logic w_map_zero;
  logic w_map_all;
  logic w_map_same;
  logic w_regrowth;

  assign w_map_zero = (i_map == '0);
  assign w_map_all  = &i_map;
  assign w_map_same = (i_map == i_stored_map);
  // A group absent from the stored map must never come back.
  assign w_regrowth = |(i_map & ~i_stored_map);

  always_comb begin
    o_result = RES_TRAIN_ERROR;
    if (i_first_check) begin
      if (w_map_zero) begin
        o_result = RES_TRAIN_ERROR;
      end else if (w_map_all) begin
        o_result = RES_CONTINUE;
      end else begin
        o_result = RES_REPEAT;
      end
    end else begin
      // An unchanged map is accepted even when no attempts remain.
      if (w_map_same) begin
        o_result = RES_CONTINUE;
      end else if (!w_map_zero && !w_regrowth && i_attempts_left) begin
        o_result = RES_REPEAT;
      end else begin
        o_result = RES_TRAIN_ERROR;
      end
    end
  end

endmodule : repairmb_map_classify
`default_nettype wire

// File: rtl/repairmb_lane_checker.sv
`default_nettype none
// ============================================================================
// Module      : repairmb_lane_checker
// Description : Partner-side REPAIRMB lane-repair checker for N lane groups.
//               Tracks a repair session across test passes, enforces the
//               monotonic-degrade rule and limits the number of repeats.
// Ports       : CLK                 - clock
//               rst                 - synchronous active-high reset
//               i_start_check       - pulse, samples i_functional_lanes
//               i_functional_lanes  - reported map, bit g=1 group g passed
//               i_abort             - ends the session (wins over start)
//               o_done_check        - pulse, result valid
//               o_continue          - map accepted
//               o_go_to_repeat      - repeat REPAIRMB with degraded map
//               o_go_to_train_error - unrecoverable
//               o_degrade_map       - last accepted/degraded map, held
//               o_attempt_cnt       - repeats issued in this session
//               o_busy              - session in progress (S_WAIT_RECHECK)
// Revision    : 1.0 - initial release
// ============================================================================
module repairmb_lane_checker
  import repairmb_pkg::*;
#(
  parameter int NUM_GROUPS   = 2,
  parameter int MAX_ATTEMPTS = 2,
  parameter int CNT_W        = $clog2(MAX_ATTEMPTS + 1)
) (
  input  logic                  CLK,
  input  logic                  rst,
  input  logic                  i_start_check,
  input  logic [NUM_GROUPS-1:0] i_functional_lanes,
  input  logic                  i_abort,
  output logic                  o_done_check,
  output logic                  o_continue,
  output logic                  o_go_to_repeat,
  output logic                  o_go_to_train_error,
  output logic [NUM_GROUPS-1:0] o_degrade_map,
  output logic [CNT_W-1:0]      o_attempt_cnt,
  output logic                  o_busy
);

  localparam logic [CNT_W-1:0] c_max_attempts = CNT_W'(MAX_ATTEMPTS);
  localparam logic [CNT_W-1:0] c_cnt_one      = CNT_W'(1);

  state_e                r_state;
  state_e                w_state_nxt;
  logic [NUM_GROUPS-1:0] r_map;
  logic [NUM_GROUPS-1:0] w_map_nxt;
  logic [CNT_W-1:0]      r_cnt;
  logic [CNT_W-1:0]      w_cnt_nxt;
  logic                  r_done;
  logic                  r_cont;
  logic                  r_rep;
  logic                  r_te;
  logic                  w_done_nxt;
  logic                  w_cont_nxt;
  logic                  w_rep_nxt;
  logic                  w_te_nxt;
  logic                  w_first_check;
  logic                  w_attempts_left;
  result_e               w_result;

  assign w_first_check   = (r_state == S_IDLE);
  assign w_attempts_left = (r_cnt < c_max_attempts);

  repairmb_map_classify #(
    .NUM_GROUPS (NUM_GROUPS)
  ) u_classify (
    .i_map           (i_functional_lanes),
    .i_stored_map    (r_map),
    .i_first_check   (w_first_check),
    .i_attempts_left (w_attempts_left),
    .o_result        (w_result)
  );

  always_ff @(posedge CLK) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_map   <= '0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
      r_cont  <= 1'b0;
      r_rep   <= 1'b0;
      r_te    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_map   <= w_map_nxt;
      r_cnt   <= w_cnt_nxt;
      r_done  <= w_done_nxt;
      r_cont  <= w_cont_nxt;
      r_rep   <= w_rep_nxt;
      r_te    <= w_te_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_map_nxt   = r_map;
    w_cnt_nxt   = r_cnt;
    w_done_nxt  = 1'b0;
    w_cont_nxt  = 1'b0;
    w_rep_nxt   = 1'b0;
    w_te_nxt    = 1'b0;

    if (i_abort) begin
      // Abort swallows any simultaneous start: no result is reported.
      w_state_nxt = S_IDLE;
      w_map_nxt   = '0;
      w_cnt_nxt   = '0;
    end else if (i_start_check) begin
      w_done_nxt = 1'b1;
      case (w_result)
        RES_CONTINUE: begin
          // On a recheck M equals S, so loading M keeps the stored map.
          w_cont_nxt  = 1'b1;
          w_state_nxt = S_IDLE;
          w_map_nxt   = i_functional_lanes;
          w_cnt_nxt   = '0;
        end
        RES_REPEAT: begin
          w_rep_nxt   = 1'b1;
          w_state_nxt = S_WAIT_RECHECK;
          w_map_nxt   = i_functional_lanes;
          w_cnt_nxt   = w_first_check ? c_cnt_one : (r_cnt + c_cnt_one);
        end
        default: begin
          w_te_nxt    = 1'b1;
          w_state_nxt = S_IDLE;
          w_map_nxt   = '0;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  assign o_done_check        = r_done;
  assign o_continue          = r_cont;
  assign o_go_to_repeat      = r_rep;
  assign o_go_to_train_error = r_te;
  assign o_degrade_map       = r_map;
  assign o_attempt_cnt       = r_cnt;
  assign o_busy              = (r_state == S_WAIT_RECHECK);

endmodule : repairmb_lane_checker
`default_nettype wire

// File: tb/tb_repairmb_lane_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_repairmb_lane_checker
// Description : Scoreboard bench for repairmb_lane_checker (4 groups, 2
//               attempts). Stimulus pushes hand-computed expected results;
//               a monitor pops and compares on every done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_repairmb_lane_checker;

  localparam int NG = 4;
  localparam int MA = 2;
  localparam int CW = 2;

  // Expected result flags in {continue, repeat, train_error} order.
  localparam logic [2:0] E_CONT = 3'b100;
  localparam logic [2:0] E_REP  = 3'b010;
  localparam logic [2:0] E_TE   = 3'b001;

  typedef struct {
    logic [2:0]    flags;
    logic [NG-1:0] map;
    logic [CW-1:0] cnt;
    logic          busy;
  } exp_t;

  logic          CLK;
  logic          rst;
  logic          i_start_check;
  logic [NG-1:0] i_functional_lanes;
  logic          i_abort;
  logic          o_done_check;
  logic          o_continue;
  logic          o_go_to_repeat;
  logic          o_go_to_train_error;
  logic [NG-1:0] o_degrade_map;
  logic [CW-1:0] o_attempt_cnt;
  logic          o_busy;

  exp_t sb_q[$];
  exp_t mon_exp;
  int   errors = 0;
  int   checks = 0;

  repairmb_lane_checker #(
    .NUM_GROUPS   (NG),
    .MAX_ATTEMPTS (MA)
  ) dut (
    .CLK                 (CLK),
    .rst                 (rst),
    .i_start_check       (i_start_check),
    .i_functional_lanes  (i_functional_lanes),
    .i_abort             (i_abort),
    .o_done_check        (o_done_check),
    .o_continue          (o_continue),
    .o_go_to_repeat      (o_go_to_repeat),
    .o_go_to_train_error (o_go_to_train_error),
    .o_degrade_map       (o_degrade_map),
    .o_attempt_cnt       (o_attempt_cnt),
    .o_busy              (o_busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Monitor: on each done pulse pop the oldest expectation and compare; in
  // any other cycle the result outputs must all be low.
  always @(negedge CLK) begin
    if (o_done_check === 1'b1) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: got flags=%b map=%b cnt=%0d, no result was expected",
                 {o_continue, o_go_to_repeat, o_go_to_train_error}, o_degrade_map, o_attempt_cnt);
      end else begin
        mon_exp = sb_q.pop_front();
        if ({o_continue, o_go_to_repeat, o_go_to_train_error} !== mon_exp.flags ||
            o_degrade_map !== mon_exp.map || o_attempt_cnt !== mon_exp.cnt ||
            o_busy !== mon_exp.busy) begin
          errors++;
          $display("FAIL result: got flags=%b map=%b cnt=%0d busy=%b, expected flags=%b map=%b cnt=%0d busy=%b",
                   {o_continue, o_go_to_repeat, o_go_to_train_error}, o_degrade_map,
                   o_attempt_cnt, o_busy, mon_exp.flags, mon_exp.map, mon_exp.cnt, mon_exp.busy);
        end
      end
    end else if (rst === 1'b0) begin
      checks++;
      if ({o_continue, o_go_to_repeat, o_go_to_train_error} !== 3'b000) begin
        errors++;
        $display("FAIL stray_result: got flags=%b without done, expected 000",
                 {o_continue, o_go_to_repeat, o_go_to_train_error});
      end
    end
  end

  // One start (optionally with abort) in a single cycle; the expectation is
  // queued only when a done pulse must follow.
  task automatic do_start(input logic [NG-1:0] m, input logic abort_too,
                          input logic [2:0] flags, input logic [NG-1:0] emap,
                          input logic [CW-1:0] ecnt, input logic ebusy);
    exp_t e;
    i_start_check      = 1'b1;
    i_functional_lanes = m;
    i_abort            = abort_too;
    if (!abort_too) begin
      e.flags = flags; e.map = emap; e.cnt = ecnt; e.busy = ebusy;
      sb_q.push_back(e);
    end
    @(posedge CLK); #1;
    i_start_check = 1'b0;
    i_abort       = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic check_state(input string name, input logic [NG-1:0] emap,
                             input logic [CW-1:0] ecnt, input logic ebusy,
                             input logic edone);
    @(negedge CLK);
    checks++;
    if (o_degrade_map !== emap || o_attempt_cnt !== ecnt || o_busy !== ebusy ||
        o_done_check !== edone) begin
      errors++;
      $display("FAIL %s: got map=%b cnt=%0d busy=%b done=%b, expected map=%b cnt=%0d busy=%b done=%b",
               name, o_degrade_map, o_attempt_cnt, o_busy, o_done_check,
               emap, ecnt, ebusy, edone);
    end
    @(posedge CLK); #1;
  endtask

  initial begin
    rst                = 1'b1;
    i_start_check      = 1'b0;
    i_functional_lanes = '0;
    i_abort            = 1'b0;
    idle(3);
    check_state("reset_values", 4'b0000, 2'd0, 1'b0, 1'b0);
    rst = 1'b0;
    idle(1);

    // Full map from idle is accepted directly.
    do_start(4'b1111, 1'b0, E_CONT, 4'b1111, 2'd0, 1'b0);
    // Degrade then recheck with the same map.
    do_start(4'b0001, 1'b0, E_REP,  4'b0001, 2'd1, 1'b1);
    do_start(4'b0001, 1'b0, E_CONT, 4'b0001, 2'd0, 1'b0);
    idle(1);
    check_state("map_held_after_continue", 4'b0001, 2'd0, 1'b0, 1'b0);

    // Two repeats then attempts exhausted.
    do_start(4'b1110, 1'b0, E_REP,  4'b1110, 2'd1, 1'b1);
    do_start(4'b0110, 1'b0, E_REP,  4'b0110, 2'd2, 1'b1);
    do_start(4'b0010, 1'b0, E_TE,   4'b0000, 2'd0, 1'b0);

    // Same map at the attempt limit is still accepted.
    do_start(4'b1110, 1'b0, E_REP,  4'b1110, 2'd1, 1'b1);
    do_start(4'b0110, 1'b0, E_REP,  4'b0110, 2'd2, 1'b1);
    do_start(4'b0110, 1'b0, E_CONT, 4'b0110, 2'd0, 1'b0);

    // Lost group reappears.
    do_start(4'b0101, 1'b0, E_REP,  4'b0101, 2'd1, 1'b1);
    do_start(4'b0111, 1'b0, E_TE,   4'b0000, 2'd0, 1'b0);

    // Recheck reporting no lanes.
    do_start(4'b0011, 1'b0, E_REP,  4'b0011, 2'd1, 1'b1);
    do_start(4'b0000, 1'b0, E_TE,   4'b0000, 2'd0, 1'b0);

    // Abort together with start: no done, session cleared.
    do_start(4'b0001, 1'b0, E_REP,  4'b0001, 2'd1, 1'b1);
    idle(1);
    do_start(4'b0001, 1'b1, E_CONT, 4'b0000, 2'd0, 1'b0);
    check_state("abort_with_start", 4'b0000, 2'd0, 1'b0, 1'b0);

    // First check with empty map.
    do_start(4'b0000, 1'b0, E_TE,   4'b0000, 2'd0, 1'b0);

    // Abort in idle clears the held map.
    do_start(4'b1111, 1'b0, E_CONT, 4'b1111, 2'd0, 1'b0);
    idle(1);
    i_abort = 1'b1;
    @(posedge CLK); #1;
    i_abort = 1'b0;
    check_state("idle_abort_clears_map", 4'b0000, 2'd0, 1'b0, 1'b0);

    // Reset mid-session drops the pending result.
    do_start(4'b0001, 1'b0, E_REP,  4'b0001, 2'd1, 1'b1);
    rst                = 1'b1;
    i_start_check      = 1'b1;
    i_functional_lanes = 4'b0001;
    @(posedge CLK); #1;
    i_start_check = 1'b0;
    check_state("reset_mid_session", 4'b0000, 2'd0, 1'b0, 1'b0);
    checks++;
    if ({o_continue, o_go_to_repeat, o_go_to_train_error} !== 3'b000) begin
      errors++;
      $display("FAIL reset_pulses: got flags=%b, expected 000",
               {o_continue, o_go_to_repeat, o_go_to_train_error});
    end
    rst = 1'b0;
    idle(3);

    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL missing_done: %0d expected results never appeared, expected 0", sb_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_repairmb_lane_checker
`default_nettype wire
